// File: rtl/w5500_frame_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | w5500_frame_pkg : shared types and sizing for the W5500 TX framer |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package w5500_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_PAY_HI = 3'd2,
        ST_PAY_LO = 3'd3,
        ST_TRL    = 3'd4,
        ST_REQ    = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    localparam int HDR_BYTES    = 4;
    localparam int TRL_BYTES    = 3;
    localparam int TX_BUF_BYTES = 2048;
    localparam int MAX_SAMPLES  = 1020;

    function automatic int frame_bytes(input int n_samples);
        return HDR_BYTES + TRL_BYTES + 2 * n_samples;
    endfunction

endpackage
`default_nettype wire

// File: rtl/w5500_tx_framer_sync_2ff.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_2ff : single-bit two-flop synchronizer                       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/w5500_tx_framer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | w5500_tx_framer : wraps 16-bit samples into sync/seq/len/chk      |
// | frames and hands them to the W5500 SPI transmit buffer. Rev 1.0   |
// +------------------------------------------------------------------+
module w5500_tx_framer
    import w5500_frame_pkg::*;
#(
    parameter int          SAMPLES_PER_FRAME = 256,
    parameter logic [15:0] SYNC_WORD         = 16'hA55A,
    parameter int          FLUSH_TIMEOUT     = 4096
) (
    input  logic        clk_sink,
    input  logic        rstn,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        busy_tx,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    output logic        tx_start,
    output logic [15:0] frame_cnt
);

    localparam logic [15:0] c_SPF        = 16'(SAMPLES_PER_FRAME);
    localparam logic [15:0] c_FLUSH_LAST = 16'(FLUSH_TIMEOUT - 1);

    generate
        if (frame_bytes(SAMPLES_PER_FRAME) > TX_BUF_BYTES - 1 ||
            SAMPLES_PER_FRAME < 1 || SAMPLES_PER_FRAME > MAX_SAMPLES) begin : g_bad_spf
            $error("SAMPLES_PER_FRAME out of range for the transmit buffer");
        end
        if (FLUSH_TIMEOUT < 2 || FLUSH_TIMEOUT > 65535) begin : g_bad_flush
            $error("FLUSH_TIMEOUT out of range");
        end
    endgenerate

    logic busy_s;

    // Reset to busy so a controller already transmitting at reset release is never overrun.
    sync_2ff #(.RST_VAL(1'b1)) u_busy_sync (
        .clk_i  (clk_sink),
        .rstn_i (rstn),
        .d_i    (busy_tx),
        .q_o    (busy_s)
    );

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] n_q, n_d;
    logic [7:0]  chk_q, chk_d;
    logic [15:0] seq_q, seq_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] idle_q, idle_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_wr_q, tx_wr_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  w_byte;
    logic        w_emit;

    always_ff @(posedge clk_sink or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            n_q         <= '0;
            chk_q       <= '0;
            seq_q       <= '0;
            frame_cnt_q <= '0;
            idle_q      <= '0;
            lo_q        <= '0;
            tx_data_q   <= '0;
            tx_wr_q     <= 1'b0;
            tx_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            n_q         <= n_d;
            chk_q       <= chk_d;
            seq_q       <= seq_d;
            frame_cnt_q <= frame_cnt_d;
            idle_q      <= idle_d;
            lo_q        <= lo_d;
            tx_data_q   <= tx_data_d;
            tx_wr_q     <= tx_wr_d;
            tx_start_q  <= tx_start_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        n_d         = n_q;
        chk_d       = chk_q;
        seq_d       = seq_q;
        frame_cnt_d = frame_cnt_q;
        idle_d      = idle_q;
        lo_d        = lo_q;
        tx_data_d   = tx_data_q;
        tx_wr_d     = 1'b0;
        tx_start_d  = 1'b0;
        w_byte      = 8'h00;
        w_emit      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                chk_d  = '0;
                n_d    = '0;
                idx_d  = '0;
                idle_d = '0;
                if (s_valid && !busy_s) state_d = ST_HDR;
            end
            ST_HDR: begin
                w_emit = 1'b1;
                case (idx_q)
                    2'd0:    w_byte = SYNC_WORD[15:8];
                    2'd1:    w_byte = SYNC_WORD[7:0];
                    2'd2:    w_byte = seq_q[15:8];
                    default: w_byte = seq_q[7:0];
                endcase
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'(HDR_BYTES - 1)) begin
                    idx_d   = '0;
                    state_d = ST_PAY_HI;
                end
            end
            ST_PAY_HI: begin
                if (s_valid) begin
                    w_emit  = 1'b1;
                    w_byte  = s_data[15:8];
                    lo_d    = s_data[7:0];
                    n_d     = n_q + 16'd1;
                    state_d = ST_PAY_LO;
                end else if (idle_q == c_FLUSH_LAST) begin
                    state_d = ST_TRL;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end
            ST_PAY_LO: begin
                w_emit  = 1'b1;
                w_byte  = lo_q;
                idle_d  = '0;
                state_d = (n_q == c_SPF) ? ST_TRL : ST_PAY_HI;
            end
            ST_TRL: begin
                w_emit = 1'b1;
                case (idx_q)
                    2'd0:    w_byte = n_q[15:8];
                    2'd1:    w_byte = n_q[7:0];
                    default: w_byte = chk_q;
                endcase
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'(TRL_BYTES - 1)) begin
                    idx_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // A busy already seen here counts as the acknowledge.
                if (busy_s) begin
                    seq_d       = seq_q + 16'd1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ST_DONE;
                end else begin
                    tx_start_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (!busy_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_emit) begin
            tx_wr_d   = 1'b1;
            tx_data_d = w_byte;
            chk_d     = chk_q ^ w_byte;
        end
    end

    assign s_ready   = (state_q == ST_PAY_HI);
    assign tx_data   = tx_data_q;
    assign tx_wr     = tx_wr_q;
    assign tx_start  = tx_start_q;
    assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire
